fluorescence_run_sequencer: RTL
===============================

// Module: fluorescence_run_sequencer
// PURPOSE
// Sequences the lock-in photon-counting datapath for a multi-window measurement run.
// Drives light-source modulation, gates the counter into add (light on) or subtract (light off) phases,
// and blanks counting for a programmable dead time after each light edge (fluorescence decay).
// Issues per-window clear/latch strobes with a valid/ready latch handshake; sits between host config and the counter.
// PARAMETERS
// TIMER_W   32  width of half-period and integration timers/config
// BLANK_W   16  width of blanking counter/config
// WINDOW_W  16  width of window count/index
// PORTS
// clock_50_mhz            in   1         system clock, all logic on posedge
// reset                   in   1         synchronous, active-high
// start                   in   1         begin run; honoured only in IDLE
// abort                   in   1         terminate run; any state -> IDLE
// cfg_half_period         in   TIMER_W   light half-period in cycles (H)
// cfg_blank_cycles        in   BLANK_W   gated-off cycles after each light edge (B)
// cfg_integration_cycles  in   TIMER_W   INTEGRATE length per window (I)
// cfg_windows             in   WINDOW_W  windows per run (N)
// latch_ack               in   1         downstream has taken latched counts
// light_source_pin        out  1         light source drive
// count_gate_add          out  1         counter adds pulses this cycle
// count_gate_sub          out  1         counter subtracts pulses this cycle
// count_clear             out  1         zero counter accumulators (1-cycle)
// count_latch             out  1         latch valid; held until latch_ack
// window_index            out  WINDOW_W  current window, 0..N-1
// busy                    out  1         high in any non-IDLE state
// run_done                out  1         1-cycle pulse after last window acked
// cfg_error               out  1         1-cycle pulse: start rejected
// BEHAVIOUR
// - All outputs registered; on reset every output is 0, state=IDLE, captured cfg cleared.
// - States: IDLE, CLEAR, INTEGRATE, LATCH, DONE.
// - IDLE: start=1 samples cfg_* into shadow regs. If any of H, I, N is 0: cfg_error pulses next cycle, stay IDLE.
//   Else go to CLEAR. cfg_* changes after start have no effect on the run.
// - CLEAR (1 cycle): count_clear=1; gates=0; light=0. Reset mod timer, window timer.
//   Load blank counter with B and set phase=on. -> INTEGRATE.
// - INTEGRATE: light_source_pin=phase.
//   - Mod timer counts 0..H-1; at H-1: toggle phase, reload blank counter with B.
//   - gate_add = phase & (blank==0); gate_sub = ~phase & (blank==0). Blank counter decrements to 0, no wrap.
//   - Each half-period therefore has exactly max(H-B,0) gated cycles; B>=H gives no gated cycles (legal).
//   - Window timer counts 0..I-1; on I-1 -> LATCH. The window is exactly I cycles, even if I is not a multiple of 2H.
//   - Gates are never both high.
// - LATCH: gates=0, light=0, count_latch=1 until latch_ack sampled high. On the ack cycle:
//   - If window_index==N-1 -> DONE.
//   - Else window_index+1 -> CLEAR.
//   - latch_ack outside LATCH is ignored.
// - DONE (1 cycle): run_done=1, window_index -> 0, -> IDLE.
// - abort in any non-IDLE state: next cycle IDLE, all outputs 0, no run_done. abort beats latch_ack and timer expiry.
// - start while busy is ignored. start and abort together in IDLE: abort wins, no run.
// - Timers saturate-free: compare with ==, widths sized so H-1, I-1 never overflow.
// TESTING
// - H=4,B=1,I=16,N=1, latch_ack tied 1:
//   - light 1111_0000_1111_0000.
//   - add high 3 cycles per on-half (6 total), sub 6 total.
//   - count_clear 1 cycle before INTEGRATE; count_latch 1 cycle; run_done next cycle.
// - N=3, ack delayed 5 cycles on window 1:
//   - count_latch held 5 cycles; window_index 0,1,2.
//   - 3 count_clear pulses, exactly 1 run_done.
// - H=4,B=4: gates never assert for full window; light still toggles every 4 cycles.
// - abort on cycle 7 of INTEGRATE:
//   - next cycle all outputs 0, busy=0, no run_done.
//   - fresh start accepted immediately, window_index restarts at 0.
// - start with N=0 (also H=0, I=0 separately): cfg_error 1-cycle pulse, busy stays 0.
// - abort with latch_ack same cycle -> IDLE, no run_done.
// - reset asserted mid-LATCH -> all outputs 0 next cycle.
// - I=10,H=4: window ends mid-half-period; exactly 10 INTEGRATE cycles.

Source files
------------

// File: rtl/fluorescence_run_sequencer.sv
// ---------------------------------------------------------------------------
// fluorescence_run_sequencer
//
// Sequences a lock-in photon-counting measurement run of N windows. Each
// window is CLEAR (zero the counter) -> INTEGRATE (modulate the light source,
// gate the counter into add/subtract phases with a blanking interval after
// every light edge) -> LATCH (hold a latch strobe until the consumer acks).
// After the last window a one-cycle run_done is issued.
//
// Ports
//   clock_50_mhz            system clock, all logic on its rising edge
//   reset                   synchronous active-high reset
//   start / abort           run control (start honoured in IDLE only,
//                           abort returns to IDLE from any state)
//   cfg_half_period (H)     light half-period in cycles
//   cfg_blank_cycles (B)    counting blanked for B cycles after each edge
//   cfg_integration_cycles  INTEGRATE length per window (I)
//   cfg_windows (N)         windows per run
//   latch_ack               consumer has taken the latched counts
//   light_source_pin        light drive
//   count_gate_add/_sub     counter add / subtract enables
//   count_clear             one-cycle counter clear
//   count_latch             latch valid, held until latch_ack
//   window_index            current window 0..N-1
//   busy                    high in every non-IDLE state
//   run_done                one-cycle pulse after the last window is acked
//   cfg_error               one-cycle pulse when a start is rejected
// ---------------------------------------------------------------------------
module fluorescence_run_sequencer #(
    parameter int TIMER_W  = 32,
    parameter int BLANK_W  = 16,
    parameter int WINDOW_W = 16
) (
    input  logic                clock_50_mhz,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [TIMER_W-1:0]  cfg_half_period,
    input  logic [BLANK_W-1:0]  cfg_blank_cycles,
    input  logic [TIMER_W-1:0]  cfg_integration_cycles,
    input  logic [WINDOW_W-1:0] cfg_windows,
    input  logic                latch_ack,
    output logic                light_source_pin,
    output logic                count_gate_add,
    output logic                count_gate_sub,
    output logic                count_clear,
    output logic                count_latch,
    output logic [WINDOW_W-1:0] window_index,
    output logic                busy,
    output logic                run_done,
    output logic                cfg_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_INTEGRATE,
        S_LATCH,
        S_DONE
    } state_t;

    state_t              state_q, state_d;

    // Configuration captured at start; the run never looks at cfg_* again.
    logic [TIMER_W-1:0]  half_q, integ_q;
    logic [BLANK_W-1:0]  blank_cfg_q;
    logic [WINDOW_W-1:0] nwin_q;
    logic                capture;

    logic [TIMER_W-1:0]  mod_q, mod_d;       // position inside half-period
    logic [TIMER_W-1:0]  win_t_q, win_t_d;   // position inside window
    logic [BLANK_W-1:0]  blank_q, blank_d;   // remaining blanked cycles
    logic                phase_q, phase_d;   // 1 = light on half
    logic [WINDOW_W-1:0] idx_q, idx_d;
    logic                cfg_bad;
    logic                err_d;

    // Registered outputs
    logic light_q, add_q, sub_q, clear_q, latch_q, busy_q, done_q, err_q;

    assign cfg_bad = (cfg_half_period == '0) || (cfg_integration_cycles == '0)
                   || (cfg_windows == '0);

    always_comb begin
        state_d = state_q;
        mod_d   = mod_q;
        win_t_d = win_t_q;
        blank_d = blank_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        capture = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    if (cfg_bad) begin
                        err_d = 1'b1;
                    end else begin
                        capture = 1'b1;
                        state_d = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                mod_d   = '0;
                win_t_d = '0;
                blank_d = blank_cfg_q;
                phase_d = 1'b1;
                state_d = S_INTEGRATE;
            end
            S_INTEGRATE: begin
                // Light edge: flip phase and restart the blanking interval.
                if (mod_q == half_q - TIMER_W'(1)) begin
                    mod_d   = '0;
                    phase_d = ~phase_q;
                    blank_d = blank_cfg_q;
                end else begin
                    mod_d = mod_q + TIMER_W'(1);
                    if (blank_q != '0) begin
                        blank_d = blank_q - BLANK_W'(1);
                    end
                end
                if (win_t_q == integ_q - TIMER_W'(1)) begin
                    state_d = S_LATCH;
                end else begin
                    win_t_d = win_t_q + TIMER_W'(1);
                end
            end
            S_LATCH: begin
                if (latch_ack) begin
                    if (idx_q == nwin_q - WINDOW_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + WINDOW_W'(1);
                        state_d = S_CLEAR;
                    end
                end
            end
            S_DONE: begin
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides every other transition, including ack and expiry.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            idx_d   = '0;
            phase_d = 1'b0;
            blank_d = '0;
            mod_d   = '0;
            win_t_d = '0;
        end
    end

    always_ff @(posedge clock_50_mhz) begin
        if (reset) begin
            state_q     <= S_IDLE;
            half_q      <= '0;
            integ_q     <= '0;
            blank_cfg_q <= '0;
            nwin_q      <= '0;
            mod_q       <= '0;
            win_t_q     <= '0;
            blank_q     <= '0;
            phase_q     <= 1'b0;
            idx_q       <= '0;
            light_q     <= 1'b0;
            add_q       <= 1'b0;
            sub_q       <= 1'b0;
            clear_q     <= 1'b0;
            latch_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            mod_q   <= mod_d;
            win_t_q <= win_t_d;
            blank_q <= blank_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            if (capture) begin
                half_q      <= cfg_half_period;
                integ_q     <= cfg_integration_cycles;
                blank_cfg_q <= cfg_blank_cycles;
                nwin_q      <= cfg_windows;
            end
            // Outputs are decoded from next-state values so that they line
            // up with the state they describe while still being registers.
            light_q <= (state_d == S_INTEGRATE) && phase_d;
            add_q   <= (state_d == S_INTEGRATE) && phase_d && (blank_d == '0);
            sub_q   <= (state_d == S_INTEGRATE) && !phase_d && (blank_d == '0);
            clear_q <= (state_d == S_CLEAR);
            latch_q <= (state_d == S_LATCH);
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
            err_q   <= err_d;
        end
    end

    assign light_source_pin = light_q;
    assign count_gate_add   = add_q;
    assign count_gate_sub   = sub_q;
    assign count_clear      = clear_q;
    assign count_latch      = latch_q;
    assign window_index     = idx_q;
    assign busy             = busy_q;
    assign run_done         = done_q;
    assign cfg_error        = err_q;

endmodule
